// File: rtl/volume_pkg.sv
// volume_pkg: shared types for the volume front-panel sequencer.
// Provides level_t, ramp_state_e and the one-step ramp helper.
package volume_pkg;

  localparam int LEVEL_W = 3;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef enum logic [1:0] {
    IDLE,
    RAMP,
    MUTED
  } ramp_state_e;

  function automatic level_t step_toward(
    level_t cur,
    level_t tgt
  );
    level_t res;
    res = cur;
    if (cur < tgt) res = cur + level_t'(1);
    else if (cur > tgt) res = cur - level_t'(1);
    return res;
  endfunction

endpackage

// File: rtl/volume_debounce.sv
// volume_debounce: 2-flop sync, debounce, press and repeat pulses.
// Ports: clk_i, reset_i (async low), btn_i raw, hold_i freezes
// repeat; state_o debounced level, pulse_o one-cycle step.
module volume_debounce
  import volume_pkg::*;
#(
  parameter int debounce_cycles_p = 16,
  parameter int repeat_delay_p    = 64,
  parameter int repeat_rate_p     = 16,
  parameter bit repeat_en_p       = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic btn_i,
  input  logic hold_i,
  output logic state_o,
  output logic pulse_o
);

  localparam int DB_W = $clog2(debounce_cycles_p + 1);
  localparam int RP_MAX = (repeat_delay_p > repeat_rate_p)
                        ? repeat_delay_p : repeat_rate_p;
  localparam int RP_W = $clog2(RP_MAX + 1);

  logic            s1_q;
  logic            s2_q;
  logic            db_q;
  logic            rep_q;
  logic            pulse_q;
  logic [DB_W-1:0] cnt_q;
  logic [RP_W-1:0] rcnt_q;
  logic            flip;
  logic [RP_W-1:0] lim;

  assign flip = (s2_q != db_q)
             && (cnt_q == DB_W'(debounce_cycles_p - 1));

  // rep_q selects the initial delay or the steady repeat rate
  assign lim = rep_q ? RP_W'(repeat_rate_p - 1)
                     : RP_W'(repeat_delay_p - 1);

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      db_q    <= 1'b0;
      rep_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;

      if (s2_q == db_q || flip) cnt_q <= '0;
      else cnt_q <= cnt_q + DB_W'(1);

      if (flip) begin
        db_q    <= s2_q;
        pulse_q <= s2_q;
        rcnt_q  <= '0;
        rep_q   <= 1'b0;
      end else if (!db_q || hold_i || !repeat_en_p) begin
        pulse_q <= 1'b0;
        rcnt_q  <= '0;
        rep_q   <= 1'b0;
      end else if (rcnt_q == lim) begin
        pulse_q <= 1'b1;
        rcnt_q  <= '0;
        rep_q   <= 1'b1;
      end else begin
        pulse_q <= 1'b0;
        rcnt_q  <= rcnt_q + RP_W'(1);
      end
    end
  end

  assign state_o = db_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/volume_ctrl.sv
// volume_ctrl: buttons -> saturating target, mute, sample ramp.
// Ports: clk_i, reset_i (async low), up_i/down_i/mute_i raw,
// sample_v_i strobe; level_o, target_o, mute_o, busy_o.
module volume_ctrl
  import volume_pkg::*;
#(
  parameter int debounce_cycles_p = 16,
  parameter int repeat_delay_p    = 64,
  parameter int repeat_rate_p     = 16,
  parameter int min_level_p       = 0,
  parameter int max_level_p       = 7,
  parameter int reset_level_p     = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic               mute_i,
  input  logic               sample_v_i,
  output logic [LEVEL_W-1:0] level_o,
  output logic [LEVEL_W-1:0] target_o,
  output logic               mute_o,
  output logic               busy_o
);

  localparam level_t MIN_L = level_t'(min_level_p);
  localparam level_t MAX_L = level_t'(max_level_p);
  localparam level_t RST_L = level_t'(reset_level_p);

  logic        up_db;
  logic        dn_db;
  logic        mute_db_unused;
  logic        up_pls;
  logic        dn_pls;
  logic        mu_pls;
  logic        both;
  logic        up_step;
  logic        dn_step;

  ramp_state_e state_q;
  ramp_state_e state_d;
  level_t      level_q;
  level_t      level_d;
  level_t      target_q;
  level_t      target_d;
  level_t      eff_q;
  level_t      eff_d;
  logic        mute_q;
  logic        mute_d;
  logic        busy_q;

  volume_debounce #(
    .debounce_cycles_p(debounce_cycles_p),
    .repeat_delay_p   (repeat_delay_p),
    .repeat_rate_p    (repeat_rate_p),
    .repeat_en_p      (1'b1)
  ) u_up (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .btn_i  (up_i),
    .hold_i (both),
    .state_o(up_db),
    .pulse_o(up_pls)
  );

  volume_debounce #(
    .debounce_cycles_p(debounce_cycles_p),
    .repeat_delay_p   (repeat_delay_p),
    .repeat_rate_p    (repeat_rate_p),
    .repeat_en_p      (1'b1)
  ) u_dn (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .btn_i  (down_i),
    .hold_i (both),
    .state_o(dn_db),
    .pulse_o(dn_pls)
  );

  volume_debounce #(
    .debounce_cycles_p(debounce_cycles_p),
    .repeat_delay_p   (repeat_delay_p),
    .repeat_rate_p    (repeat_rate_p),
    .repeat_en_p      (1'b0)
  ) u_mu (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .btn_i  (mute_i),
    .hold_i (1'b0),
    .state_o(mute_db_unused),
    .pulse_o(mu_pls)
  );

  // A pulse always implies its button is debounced-high, so
  // gating by both-held also makes the two steps exclusive.
  assign both    = up_db & dn_db;
  assign up_step = up_pls & ~both;
  assign dn_step = dn_pls & ~both;

  always_comb begin
    target_d = target_q;
    unique case (1'b1)
      up_step: target_d = (target_q > MIN_L)
                        ? target_q - level_t'(1) : MIN_L;
      dn_step: target_d = (target_q < MAX_L)
                        ? target_q + level_t'(1) : MAX_L;
      default: ;
    endcase
  end

  assign mute_d = mute_q ^ mu_pls;
  assign eff_q  = mute_q ? MAX_L : target_q;
  assign eff_d  = mute_d ? MAX_L : target_d;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      IDLE: begin
        if (mute_d && level_q == MAX_L) state_d = MUTED;
        else if (level_q != eff_q) state_d = RAMP;
      end
      RAMP: begin
        if (sample_v_i) level_d = step_toward(level_q, eff_q);
        if (mute_d && level_d == MAX_L) state_d = MUTED;
        else if (level_d == eff_q) state_d = IDLE;
      end
      MUTED: begin
        if (mu_pls) state_d = (target_d == MAX_L) ? IDLE : RAMP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q  <= IDLE;
      level_q  <= RST_L;
      target_q <= RST_L;
      mute_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      mute_q   <= mute_d;
      busy_q   <= (level_d != eff_d);
    end
  end

  assign level_o  = level_q;
  assign target_o = target_q;
  assign mute_o   = (state_q == MUTED);
  assign busy_o   = busy_q;

endmodule

// File: tb/tb_volume_ctrl.sv
// tb_volume_ctrl: directed self-checking bench for volume_ctrl.
// Debounce 4, delay 8, rate 4, levels 0..7, reset level 4.
module tb_volume_ctrl;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       up_i;
  logic       down_i;
  logic       mute_i;
  logic       sample_v_i;
  logic [2:0] level_o;
  logic [2:0] target_o;
  logic       mute_o;
  logic       busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  volume_ctrl #(
    .debounce_cycles_p(4),
    .repeat_delay_p   (8),
    .repeat_rate_p    (4),
    .min_level_p      (0),
    .max_level_p      (7),
    .reset_level_p    (4)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .up_i      (up_i),
    .down_i    (down_i),
    .mute_i    (mute_i),
    .sample_v_i(sample_v_i),
    .level_o   (level_o),
    .target_o  (target_o),
    .mute_o    (mute_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Each call step advances n posedges, ending at a negedge;
  // the strobe toggles so sample_v_i is high every 2nd cycle.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      sample_v_i = ~sample_v_i;
    end
  endtask

  initial begin
    reset_i    = 1'b0;
    up_i       = 1'b0;
    down_i     = 1'b0;
    mute_i     = 1'b0;
    sample_v_i = 1'b0;
    cyc(2);
    chk("rst_level", {1'b0, level_o}, 4'd4);
    chk("rst_target", {1'b0, target_o}, 4'd4);
    chk("rst_mute", {3'b0, mute_o}, 4'd0);
    chk("rst_busy", {3'b0, busy_o}, 4'd0);
    reset_i = 1'b1;
    cyc(3);

    // single clean up press, 6 cycles
    up_i = 1'b1;
    cyc(6);
    chk("up_e6_tgt", {1'b0, target_o}, 4'd4);
    up_i = 1'b0;
    cyc(1);
    chk("up_e7_tgt", {1'b0, target_o}, 4'd3);
    chk("up_e7_lvl", {1'b0, level_o}, 4'd4);
    chk("up_e7_busy", {3'b0, busy_o}, 4'd1);
    cyc(8);
    chk("up_lvl", {1'b0, level_o}, 4'd3);
    chk("up_busy", {3'b0, busy_o}, 4'd0);
    cyc(8);

    // 3-cycle glitch is rejected
    up_i = 1'b1;
    cyc(3);
    up_i = 1'b0;
    cyc(15);
    chk("glitch_tgt", {1'b0, target_o}, 4'd3);

    // bouncing down settles high: exactly one step
    down_i = 1'b1; cyc(1);
    down_i = 1'b0; cyc(1);
    down_i = 1'b1; cyc(2);
    down_i = 1'b0; cyc(1);
    down_i = 1'b1; cyc(6);
    chk("bounce_e11", {1'b0, target_o}, 4'd3);
    down_i = 1'b0;
    cyc(1);
    chk("bounce_e12", {1'b0, target_o}, 4'd4);
    cyc(20);
    chk("bounce_once", {1'b0, target_o}, 4'd4);
    chk("bounce_lvl", {1'b0, level_o}, 4'd4);

    // auto-repeat and saturation
    down_i = 1'b1;
    cyc(6);
    chk("rep_e6", {1'b0, target_o}, 4'd4);
    cyc(1);
    chk("rep_e7", {1'b0, target_o}, 4'd5);
    cyc(7);
    chk("rep_e14", {1'b0, target_o}, 4'd5);
    cyc(1);
    chk("rep_e15", {1'b0, target_o}, 4'd6);
    cyc(3);
    chk("rep_e18", {1'b0, target_o}, 4'd6);
    cyc(1);
    chk("rep_e19", {1'b0, target_o}, 4'd7);
    cyc(4);
    chk("rep_e23", {1'b0, target_o}, 4'd7);
    cyc(17);
    chk("rep_e40", {1'b0, target_o}, 4'd7);
    down_i = 1'b0;
    cyc(25);
    chk("rep_lvl", {1'b0, level_o}, 4'd7);
    chk("rep_busy", {3'b0, busy_o}, 4'd0);

    // both held: frozen; release down restarts up delay
    up_i   = 1'b1;
    down_i = 1'b1;
    cyc(7);
    chk("both_e7", {1'b0, target_o}, 4'd7);
    cyc(13);
    chk("both_e20", {1'b0, target_o}, 4'd7);
    down_i = 1'b0;
    cyc(10);
    up_i = 1'b0;
    cyc(4);
    chk("both_rel_e14", {1'b0, target_o}, 4'd7);
    cyc(1);
    chk("both_rel_e15", {1'b0, target_o}, 4'd6);
    cyc(12);
    chk("both_norep", {1'b0, target_o}, 4'd6);
    chk("both_lvl", {1'b0, level_o}, 4'd6);

    // walk target down to 2 by holding up
    up_i = 1'b1;
    cyc(20);
    up_i = 1'b0;
    cyc(3);
    chk("to2_tgt", {1'b0, target_o}, 4'd2);
    cyc(30);
    chk("to2_lvl", {1'b0, level_o}, 4'd2);

    // mute press ramps 2 -> 7 then mutes
    mute_i = 1'b1;
    cyc(6);
    mute_i = 1'b0;
    cyc(1);
    chk("mute_e7_m", {3'b0, mute_o}, 4'd0);
    chk("mute_e7_busy", {3'b0, busy_o}, 4'd1);
    cyc(20);
    chk("mute_on", {3'b0, mute_o}, 4'd1);
    chk("mute_lvl", {1'b0, level_o}, 4'd7);
    chk("mute_busy", {3'b0, busy_o}, 4'd0);

    // down while muted changes target only
    down_i = 1'b1;
    cyc(6);
    down_i = 1'b0;
    cyc(1);
    chk("mdn_tgt", {1'b0, target_o}, 4'd3);
    chk("mdn_mute", {3'b0, mute_o}, 4'd1);
    chk("mdn_lvl", {1'b0, level_o}, 4'd7);
    cyc(15);

    // unmute drops mute_o at once, then ramps 7 -> 3
    mute_i = 1'b1;
    cyc(6);
    chk("um_e6", {3'b0, mute_o}, 4'd1);
    mute_i = 1'b0;
    cyc(1);
    chk("um_e7", {3'b0, mute_o}, 4'd0);
    chk("um_e7_lvl", {1'b0, level_o}, 4'd7);
    chk("um_e7_busy", {3'b0, busy_o}, 4'd1);
    cyc(20);
    chk("um_lvl", {1'b0, level_o}, 4'd3);
    chk("um_busy", {3'b0, busy_o}, 4'd0);

    // reset mid-ramp with down held
    down_i = 1'b1;
    cyc(20);
    chk("pre_rst_tgt", {1'b0, target_o}, 4'd6);
    reset_i = 1'b0;
    #1;
    chk("arst_level", {1'b0, level_o}, 4'd4);
    chk("arst_target", {1'b0, target_o}, 4'd4);
    chk("arst_mute", {3'b0, mute_o}, 4'd0);
    chk("arst_busy", {3'b0, busy_o}, 4'd0);
    cyc(3);
    reset_i = 1'b1;
    cyc(6);
    chk("post_rst_e6", {1'b0, target_o}, 4'd4);
    cyc(1);
    chk("post_rst_e7", {1'b0, target_o}, 4'd5);
    down_i = 1'b0;
    cyc(20);
    chk("post_rst_lvl", {1'b0, level_o}, 4'd5);
    chk("post_rst_busy", {3'b0, busy_o}, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
